block_deinterleaver: RTL

Row-column block deinterleaver for the receive path; it sits directly downstream of the interleaver. It accepts one interleaved ROWS×COLS-bit block per strobe, restores the original bit order, and emits the block as a serial bit stream. Two ping-pong banks let the next block be captured while the current one is shifted out. A sticky flag reports blocks dropped when both banks are occupied.

---
 rtl/block_deinterleaver.sv | 112 +++++++++++
 1 files changed

// File: rtl/block_deinterleaver.sv
// Row-column block deinterleaver: captures one interleaved ROWS*COLS block per strobe
// into ping-pong banks and shifts the restored bit order out serially, bit 0 first.
module block_deinterleaver #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ROWS*COLS-1:0] din,
  input  logic                 din_valid,
  output logic                 dout,
  output logic                 dout_valid,
  output logic                 sof,
  output logic                 busy,
  output logic                 ovf
);
  localparam int W  = ROWS * COLS;
  localparam int IW = (W > 1) ? $clog2(W) : 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;

  logic [0:0]   state;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [W-1:0] bank [2];
  logic [W-1:0] din_perm;
  logic [1:0]   full;
  logic [1:0]   full_nxt;
  logic         wr_ptr;
  logic         rd_ptr;
  logic         last;
  logic         accept;

  // Banks hold the block already in original order, so the serializer just walks idx.
  for (genvar i = 0; i < W; i++) begin : g_perm
    assign din_perm[i] = din[(i % COLS) * ROWS + i / COLS];
  end

  assign idx_nxt = idx + 1'b1;
  assign busy    = full[0] | full[1] | (state == SHIFT);

  always_comb begin
    last     = (state == SHIFT) && (idx == IW'(W - 1));
    // A bank being released on this edge can take the incoming block.
    accept   = din_valid && (!full[wr_ptr] || (last && (rd_ptr == wr_ptr)));
    full_nxt = full;
    if (last)   full_nxt[rd_ptr] = 1'b0;
    if (accept) full_nxt[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank[0]    <= '0;
      bank[1]    <= '0;
      full       <= 2'b00;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      ovf        <= 1'b0;
      state      <= IDLE;
      idx        <= '0;
      dout       <= 1'b0;
      dout_valid <= 1'b0;
      sof        <= 1'b0;
    end else begin
      full <= full_nxt;
      if (accept) begin
        bank[wr_ptr] <= din_perm;
        wr_ptr       <= ~wr_ptr;
      end
      if (din_valid && !accept) ovf <= 1'b1;

      case (state)
        IDLE: begin
          if (full[rd_ptr]) begin
            state      <= SHIFT;
            idx        <= '0;
            dout       <= bank[rd_ptr][0];
            dout_valid <= 1'b1;
            sof        <= 1'b1;
          end else begin
            dout       <= 1'b0;
            dout_valid <= 1'b0;
            sof        <= 1'b0;
          end
        end
        default: begin
          if (last) begin
            rd_ptr <= ~rd_ptr;
            // Other bank already waiting: chain the next frame with no idle gap.
            if (full[~rd_ptr]) begin
              idx        <= '0;
              dout       <= bank[~rd_ptr][0];
              dout_valid <= 1'b1;
              sof        <= 1'b1;
            end else begin
              state      <= IDLE;
              dout       <= 1'b0;
              dout_valid <= 1'b0;
              sof        <= 1'b0;
            end
          end else begin
            idx        <= idx_nxt;
            dout       <= bank[rd_ptr][idx_nxt];
            dout_valid <= 1'b1;
            sof        <= 1'b0;
          end
        end
      endcase
    end
  end
endmodule
